// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//
// Sequences a WIDTH-bit add or subtract through one external 4-bit ripple
// carry adder slice, one nibble per clock, least-significant nibble first.
// The carry between nibbles is held in an internal register, so the same
// slice serves any WIDTH that is a multiple of 4.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and
// ready are both high. The operand side is ready only in IDLE. Once
// out_valid_o rises, it stays high, and sum_o/cout_o/ovf_o stay constant,
// until out_ready_i is seen high on a rising edge.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   in_valid_i/in_ready_o operand request handshake
//   a_i, b_i              WIDTH-bit operands
//   cin_i                 carry-in for add (ignored for subtract)
//   op_sub_i              0: a+b+cin, 1: a-b computed as a + ~b + 1
//   adder_a_o/b_o/cin_o   nibble operands and chained carry to the slice
//   adder_sum_i/cout_i    combinational slice response
//   out_valid_o/out_ready_i result handshake
//   sum_o, cout_o, ovf_o  result, final carry (1 = no borrow on subtract),
//                         signed overflow
//   busy_o                high while an operation is in flight or unclaimed
//
// The FSM state is held in the enum-typed variable 'state' for probing.

module nibble_serial_adder_ctrl #(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             op_sub_i,
    output logic [3:0]       adder_a_o,
    output logic [3:0]       adder_b_o,
    output logic             adder_cin_o,
    input  logic [3:0]       adder_sum_i,
    input  logic             adder_cout_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             busy_o
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0 || NIBBLES != WIDTH / 4) begin : g_bad_width
            $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4, at least 4, and NIBBLES must equal WIDTH/4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0] idx;
    logic [IDX_W+1:0] bit_base;     // 4*idx, the LSB of the current nibble
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_eff;        // b already complemented for subtract
    logic [WIDTH-1:0] sum_stage;    // partial result, kept off sum_o until done
    logic [WIDTH-1:0] sum_merged;   // sum_stage with the current nibble inserted
    logic             accept;
    logic             last_nibble;

    assign bit_base    = {idx, 2'b00};
    assign accept      = in_valid_i && in_ready_o;
    assign last_nibble = (idx == LAST_IDX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        adder_a_o   = 4'd0;
        adder_b_o   = 4'd0;
        adder_cin_o = 1'b0;
        case (state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy_o      = 1'b1;
                adder_a_o   = a_reg[bit_base +: 4];
                adder_b_o   = b_eff[bit_base +: 4];
                adder_cin_o = carry;
                if (last_nibble) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        sum_merged                 = sum_stage;
        sum_merged[bit_base +: 4]  = adder_sum_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_eff     <= '0;
            sum_stage <= '0;
            sum_o     <= '0;
            cout_o    <= 1'b0;
            ovf_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg <= a_i;
                        b_eff <= op_sub_i ? ~b_i : b_i;
                        carry <= op_sub_i ? 1'b1 : cin_i;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum_stage <= sum_merged;
                    carry     <= adder_cout_i;
                    idx       <= idx + 1'b1;
                    if (last_nibble) begin
                        // Results are published only here, all at once.
                        sum_o  <= sum_merged;
                        cout_o <= adder_cout_i;
                        ovf_o  <= (a_reg[WIDTH-1] == b_eff[WIDTH-1]) &&
                                  (adder_sum_i[3] != a_reg[WIDTH-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
module tb_nibble_serial_adder_ctrl;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         op_sub;
    logic [3:0]   adder_a;
    logic [3:0]   adder_b;
    logic         adder_cin;
    logic [3:0]   adder_sum;
    logic         adder_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum_out;
    logic         cout_out;
    logic         ovf_out;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] last_sum;
    logic         last_cout;
    logic         last_ovf;

    always #5 clk = ~clk;

    // External 4-bit ripple carry slice.
    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {4'd0, adder_cin};

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .a_i          (a_in),
        .b_i          (b_in),
        .cin_i        (cin_in),
        .op_sub_i     (op_sub),
        .adder_a_o    (adder_a),
        .adder_b_o    (adder_b),
        .adder_cin_o  (adder_cin),
        .adder_sum_i  (adder_sum),
        .adder_cout_i (adder_cout),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .sum_o        (sum_out),
        .cout_o       (cout_out),
        .ovf_o        (ovf_out),
        .busy_o       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, output logic [W-1:0] s, output logic co,
                         output logic ov, output logic [N-1:0] cseq);
        longint ua, ub, eb, c0, full, sa, sb, sr, lo_mask;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c0 = sub ? 1 : longint'(cin);
        full = sub ? ua + (longint'(1) << W) - ub : ua + ub + c0;
        sr   = sub ? sa - sb : sa + sb + c0;
        s  = full[W-1:0];
        co = full[W];
        ov = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
        eb = sub ? ((longint'(1) << W) - 1 - ub) : ub;
        for (int k = 0; k < N; k++) begin
            lo_mask = (longint'(1) << (4 * k)) - 1;
            cseq[k] = (((ua & lo_mask) + (eb & lo_mask) + c0) >> (4 * k)) != 0;
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, input int hold, input string name);
        logic [W-1:0] es;
        logic         eco, eov;
        logic [N-1:0] ecseq, ocseq;
        model(a, b, cin, sub, es, eco, eov, ecseq);
        check({name, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; a_in = a; b_in = b; cin_in = cin; op_sub = sub;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom); cin_in = 1'($urandom); op_sub = 1'($urandom);
        for (int k = 0; k < N; k++) begin
            check({name, ".run_valid"}, 32'(out_valid), 32'd0);
            check({name, ".run_ready"}, 32'(in_ready), 32'd0);
            check({name, ".run_busy"}, 32'(busy), 32'd1);
            check({name, ".run_sum_hold"}, 32'(sum_out), 32'(last_sum));
            check({name, ".adder_a"}, 32'(adder_a), 32'((a >> (4 * k)) & 16'hF));
            ocseq[k] = adder_cin;
            @(posedge clk); #1;
        end
        check({name, ".cin_seq"}, 32'(ocseq), 32'(ecseq));
        check({name, ".valid"}, 32'(out_valid), 32'd1);
        check({name, ".sum"}, 32'(sum_out), 32'(es));
        check({name, ".cout"}, 32'(cout_out), 32'(eco));
        check({name, ".ovf"}, 32'(ovf_out), 32'(eov));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a_in = W'($urandom); b_in = W'($urandom);
            @(posedge clk); #1;
            check({name, ".bp_valid"}, 32'(out_valid), 32'd1);
            check({name, ".bp_ready"}, 32'(in_ready), 32'd0);
            check({name, ".bp_sum"}, 32'(sum_out), 32'(es));
            check({name, ".bp_adder_a"}, 32'(adder_a), 32'd0);
        end
        // Keep in_valid high (when hold>0) through the handshake edge: it must not be accepted.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({name, ".post_valid"}, 32'(out_valid), 32'd0);
        check({name, ".post_ready"}, 32'(in_ready), 32'd1);
        check({name, ".post_busy"}, 32'(busy), 32'd0);
        check({name, ".post_sum"}, 32'(sum_out), 32'(es));
        last_sum = es; last_cout = eco; last_ovf = eov;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0; cin_in = 1'b0; op_sub = 1'b0;
        last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
        @(posedge clk); #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.sum", 32'(sum_out), 32'd0);
        check("rst.cout", 32'(cout_out), 32'd0);
        check("rst.ovf", 32'(ovf_out), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.adder", 32'({adder_a, adder_b, adder_cin}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(16'h1234, 16'h0FED, 1'b0, 1'b0, 0, "add_basic");
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "add_ripple");
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "add_ovf");
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, "sub_ovf");
        do_op(16'h0003, 16'h0005, 1'b1, 1'b1, 0, "sub_borrow");
        do_op(16'h5555, 16'h2222, 1'b1, 1'b0, 5, "backpressure");
        do_op(16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 0, "after_bp");

        // Reset in the middle of RUN, with a carry pending at idx==2.
        in_valid = 1'b1; a_in = 16'hFFFF; b_in = 16'h0001; cin_in = 1'b0; op_sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid.adder_cin", 32'(adder_cin), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst.out_valid", 32'(out_valid), 32'd0);
        check("mid_rst.sum", 32'(sum_out), 32'd0);
        check("mid_rst.cout_ovf", 32'({cout_out, ovf_out}), 32'd0);
        check("mid_rst.busy", 32'(busy), 32'd0);
        check("mid_rst.adder", 32'({adder_a, adder_b, adder_cin}), 32'd0);
        check("mid_rst.in_ready", 32'(in_ready), 32'd1);
        last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, "after_rst");

        for (int i = 0; i < 30; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
